wb_regfile: RTL

Writeback stage and integer register file for the 5-stage RV32 pipeline. It consumes the MEM/WB pipeline register outputs, selects the writeback value, and commits it to a 32 x 32 register file. It also provides the two combinational read ports used by decode, with same-cycle write-through bypass. A 64-bit retired-instruction counter tracks writebacks.

---
 rtl/wb_regfile.sv | 49 ++++
 1 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: RV32 writeback mux, 32x32 register file with write-through bypass, retired-instruction counter
module wb_regfile #(
  parameter int datawidth = 32,
  parameter int regindex  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic [datawidth-1:0] DataMEM_in,
  input  logic [datawidth-1:0] DataALU_in,
  input  logic [31:0]          MEM_WB_PC_in,
  input  logic [regindex-1:0]  regdindex_in,
  input  logic [1:0]           WBsel_in,
  input  logic                 Regwrite_in,
  input  logic [regindex-1:0]  rs1_index,
  input  logic [regindex-1:0]  rs2_index,
  output logic [datawidth-1:0] rs1_data,
  output logic [datawidth-1:0] rs2_data,
  output logic [datawidth-1:0] wb_data,
  output logic                 wb_we,
  output logic [63:0]          instret
);
  localparam int nregs = 2 ** regindex;
  logic [datawidth-1:0] regs_q [nregs];
  logic [datawidth-1:0] regs_d [nregs];
  logic [63:0]          instret_q, instret_d;
  logic [31:0]          pc4;
  always_comb begin
    pc4      = MEM_WB_PC_in + 32'd4;
    wb_data  = WBsel_in == 2'b01 ? DataMEM_in : WBsel_in == 2'b10 ? datawidth'(pc4) : DataALU_in;
    wb_we    = wb_valid & Regwrite_in & (regdindex_in != '0) & ~rst;
    rs1_data = rs1_index == '0 ? '0 : (wb_we && rs1_index == regdindex_in) ? wb_data : regs_q[rs1_index];
    rs2_data = rs2_index == '0 ? '0 : (wb_we && rs2_index == regdindex_in) ? wb_data : regs_q[rs2_index];
    regs_d   = regs_q;
    if (wb_we) regs_d[regdindex_in] = wb_data;
    regs_d[0] = '0;
    instret_d = instret_q + {63'd0, wb_valid};
    instret   = instret_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q    <= '{default: '0};
      instret_q <= '0;
    end else begin
      regs_q    <= regs_d;
      instret_q <= instret_d;
    end
  end
endmodule
